// File: rtl/instr_buffer_pkg.sv
// Shared instruction-buffer sizing and entry layout, used by fetch, the buffer and decode.
package instr_buffer_pkg;

  localparam int IB_WIDTH_LOG2  = 4;
  localparam int IB_DATA_BUS_WD = 81;
  localparam int IB_PUSH_SLOTS  = 4;
  localparam int IB_READ_SLOTS  = 2;

  // Field order from MSB to LSB matches the packed bus carried by if1_to_ib / ib_to_id.
  typedef struct packed {
    logic        is_jump;
    logic        excp;
    logic [5:0]  ecode;
    logic [8:0]  sub_ecode;
    logic [31:0] pc;
    logic [31:0] inst;
  } ib_entry_t;

endpackage

// File: rtl/instr_buffer_storage.sv
// Entry array for the instruction buffer: four write ports, two asynchronous read ports.
module ib_storage
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = IB_WIDTH_LOG2,
  parameter int DATA_W     = IB_DATA_BUS_WD
) (
  input  logic                                       clk,
  input  logic [IB_PUSH_SLOTS-1:0]                   we,
  input  logic [IB_PUSH_SLOTS-1:0][DEPTH_LOG2-1:0]   waddr,
  input  logic [IB_PUSH_SLOTS*DATA_W-1:0]            wdata,
  input  logic [DEPTH_LOG2-1:0]                      raddr0,
  input  logic [DEPTH_LOG2-1:0]                      raddr1,
  output logic [DATA_W-1:0]                          rdata0,
  output logic [DATA_W-1:0]                          rdata1
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Contents are deliberately never reset; validity is tracked by the pointer logic.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < IB_PUSH_SLOTS; k++) begin
      if (we[k]) mem[waddr[k]] <= wdata[k*DATA_W +: DATA_W];
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: up to 4 pushes and 2 pops per cycle.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = IB_WIDTH_LOG2,
  parameter int DATA_W     = IB_DATA_BUS_WD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_IB,
  input  logic [4*DATA_W-1:0]          if1_to_ib,
  input  logic [2:0]                   push_num,
  output logic [DEPTH_LOG2:0]          can_push_size,
  output logic [2*DATA_W-1:0]          ib_to_id,
  output logic [1:0]                   ib_valid,
  input  logic [1:0]                   pop_num
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] head, tail;
  logic [CW-1:0]         count;
  logic [CW-1:0]         pop_ext, push_ext, eff_pop, push_acc;
  logic [CW:0]           fill;
  logic                  push_ok;
  logic [IB_PUSH_SLOTS-1:0]                 we;
  logic [IB_PUSH_SLOTS-1:0][DEPTH_LOG2-1:0] waddr;

  always_comb begin
    pop_ext  = CW'(pop_num);
    push_ext = CW'(push_num);
    eff_pop  = (pop_ext > count) ? count : pop_ext;
    // Contract check uses occupancy before this cycle's pop, so a violating push is dropped whole.
    fill     = {1'b0, count} + {1'b0, push_ext};
    push_ok  = (fill <= (CW+1)'(DEPTH - 1));
    push_acc = push_ok ? push_ext : '0;
  end

  genvar gk;
  generate
    for (gk = 0; gk < IB_PUSH_SLOTS; gk++) begin : g_wport
      assign we[gk]    = !rst && !flush_IB && push_ok && (3'(gk) < push_num);
      assign waddr[gk] = tail + DEPTH_LOG2'(gk);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush_IB) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + eff_pop[DEPTH_LOG2-1:0];
      tail  <= tail + push_acc[DEPTH_LOG2-1:0];
      count <= count - eff_pop + push_acc;
    end
  end

  always @(posedge clk) begin
    if (!rst && !flush_IB) begin
      assert (push_ok)
        else $warning("instr_buffer: push of %0d dropped at occupancy %0d", push_num, count);
    end
  end

  ib_storage #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_storage (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (if1_to_ib),
    .raddr0 (head),
    .raddr1 (head + DEPTH_LOG2'(1)),
    .rdata0 (ib_to_id[DATA_W-1:0]),
    .rdata1 (ib_to_id[2*DATA_W-1:DATA_W])
  );

  assign can_push_size = count;
  assign ib_valid      = {count >= CW'(2), count != '0};

endmodule

// File: tb/tb_instr_buffer.sv
// Directed plus randomized bench for instr_buffer against a queue-based reference model.
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int DW    = IB_DATA_BUS_WD;
  localparam int DL    = IB_WIDTH_LOG2;
  localparam int DEPTH = 1 << DL;

  logic            clk;
  logic            rst;
  logic            flush_IB;
  logic [4*DW-1:0] if1_to_ib;
  logic [2:0]      push_num;
  logic [DL:0]     can_push_size;
  logic [2*DW-1:0] ib_to_id;
  logic [1:0]      ib_valid;
  logic [1:0]      pop_num;

  instr_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .flush_IB      (flush_IB),
    .if1_to_ib     (if1_to_ib),
    .push_num      (push_num),
    .can_push_size (can_push_size),
    .ib_to_id      (ib_to_id),
    .ib_valid      (ib_valid),
    .pop_num       (pop_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] slots[4];
  int m_head, m_tail;
  int n_pass, n_fail, n_total;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_entry();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic rand_slots();
    for (int k = 0; k < 4; k++) slots[k] = rand_entry();
  endtask

  task automatic apply(input int pn, input int pp, input bit fl, input bit rs);
    push_num  = 3'(pn);
    pop_num   = 2'(pp);
    flush_IB  = fl;
    rst       = rs;
    if1_to_ib = {slots[3], slots[2], slots[1], slots[0]};
  endtask

  // One clock: drive, advance the model by the buffer's rules, then idle the inputs.
  task automatic drive_cycle(input int pn, input int pp, input bit fl, input bit rs);
    int eff, sz;
    bit legal;
    apply(pn, pp, fl, rs);
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      sz    = model_q.size();
      eff   = (pp < sz) ? pp : sz;
      legal = (sz + pn) <= (DEPTH - 1);
      repeat (eff) void'(model_q.pop_front());
      m_head = (m_head + eff) % DEPTH;
      if (legal) begin
        for (int k = 0; k < pn; k++) model_q.push_back(slots[k]);
        m_tail = (m_tail + pn) % DEPTH;
      end
    end
    #1;
    apply(0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, "_count"}, 128'(can_push_size), 128'(sz));
    chk({tag, "_valid"}, 128'(ib_valid), 128'({sz >= 2, sz >= 1}));
    if (sz >= 1) chk({tag, "_slot0"}, 128'(ib_to_id[DW-1:0]), 128'(model_q[0]));
    if (sz >= 2) chk({tag, "_slot1"}, 128'(ib_to_id[2*DW-1:DW]), 128'(model_q[1]));
    chk({tag, "_head"}, 128'(dut.head), 128'(m_head));
    chk({tag, "_tail"}, 128'(dut.tail), 128'(m_tail));
  endtask

  initial begin
    ib_entry_t e;
    int old_tail, pn, pp, sz;
    bit fl, rs;
    n_pass = 0; n_fail = 0; n_total = 0;
    m_head = 0; m_tail = 0;
    rand_slots();
    apply(0, 0, 1'b0, 1'b1);

    // Reset
    drive_cycle(0, 0, 1'b0, 1'b1);
    drive_cycle(0, 0, 1'b0, 1'b1);
    check_state("reset");

    // First push of four sequential PCs; nothing visible before the edge
    rand_slots();
    for (int k = 0; k < 4; k++) begin
      e = slots[k];
      e.pc = 32'h1c00_0000 + 32'(4 * k);
      slots[k] = e;
    end
    apply(4, 0, 1'b0, 1'b0);
    #1;
    chk("nobypass_valid", 128'(ib_valid), 128'(2'b00));
    chk("nobypass_count", 128'(can_push_size), 128'(0));
    drive_cycle(4, 0, 1'b0, 1'b0);
    check_state("push4");
    e = ib_to_id[DW-1:0];
    chk("push4_pc0", 128'(e.pc), 128'(32'h1c00_0000));
    e = ib_to_id[2*DW-1:DW];
    chk("push4_pc1", 128'(e.pc), 128'(32'h1c00_0004));

    // Simultaneous push 2 / pop 2 at count 3
    drive_cycle(0, 1, 1'b0, 1'b0);
    check_state("pop1");
    rand_slots();
    old_tail = m_tail;
    drive_cycle(2, 2, 1'b0, 1'b0);
    check_state("pushpop");
    chk("pushpop_mem0", 128'(dut.u_storage.mem[old_tail]), 128'(slots[0]));
    chk("pushpop_mem1", 128'(dut.u_storage.mem[(old_tail + 1) % DEPTH]), 128'(slots[1]));

    // Walk pointers to head=10, tail=14, count=4, then push across the wrap
    drive_cycle(0, 0, 1'b1, 1'b0);
    check_state("flush_a");
    rand_slots(); drive_cycle(4, 0, 1'b0, 1'b0);
    rand_slots(); drive_cycle(4, 2, 1'b0, 1'b0);
    rand_slots(); drive_cycle(4, 2, 1'b0, 1'b0);
    rand_slots(); drive_cycle(2, 2, 1'b0, 1'b0);
    drive_cycle(0, 2, 1'b0, 1'b0);
    drive_cycle(0, 2, 1'b0, 1'b0);
    check_state("prewrap");
    chk("prewrap_tail14", 128'(dut.tail), 128'(14));
    chk("prewrap_head10", 128'(dut.head), 128'(10));
    rand_slots();
    drive_cycle(4, 0, 1'b0, 1'b0);
    check_state("wrap");
    chk("wrap_mem14", 128'(dut.u_storage.mem[14]), 128'(slots[0]));
    chk("wrap_mem15", 128'(dut.u_storage.mem[15]), 128'(slots[1]));
    chk("wrap_mem0",  128'(dut.u_storage.mem[0]),  128'(slots[2]));
    chk("wrap_mem1",  128'(dut.u_storage.mem[1]),  128'(slots[3]));
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 2, 1'b0, 1'b0);
      check_state("wrap_drain");
    end
    chk("wrap_drain_empty", 128'(can_push_size), 128'(0));

    // Pop more than held
    rand_slots(); drive_cycle(1, 0, 1'b0, 1'b0);
    check_state("one");
    drive_cycle(0, 2, 1'b0, 1'b0);
    check_state("overpop");
    chk("overpop_valid", 128'(ib_valid), 128'(2'b00));

    // Overflowing push is dropped whole
    for (int i = 0; i < 3; i++) begin rand_slots(); drive_cycle(4, 0, 1'b0, 1'b0); end
    rand_slots(); drive_cycle(1, 0, 1'b0, 1'b0);
    check_state("at13");
    rand_slots(); drive_cycle(3, 0, 1'b0, 1'b0);
    check_state("drop3");
    chk("drop3_count", 128'(can_push_size), 128'(13));
    rand_slots(); drive_cycle(2, 0, 1'b0, 1'b0);
    check_state("fill15");
    chk("fill15_count", 128'(can_push_size), 128'(15));

    // Flush beats push/pop; reset together with flush behaves the same
    for (int i = 0; i < 3; i++) drive_cycle(0, 2, 1'b0, 1'b0);
    check_state("at9");
    rand_slots(); drive_cycle(4, 2, 1'b1, 1'b0);
    check_state("flush9");
    rand_slots(); drive_cycle(4, 0, 1'b0, 1'b0);
    rand_slots(); drive_cycle(4, 0, 1'b0, 1'b0);
    rand_slots(); drive_cycle(1, 0, 1'b0, 1'b0);
    check_state("refill9");
    rand_slots(); drive_cycle(4, 2, 1'b1, 1'b1);
    check_state("rstflush");

    // Randomized traffic, mostly within the sender contract
    for (int i = 0; i < 400; i++) begin
      rand_slots();
      sz = model_q.size();
      pn = $urandom_range(0, 4);
      if ((sz + pn) > (DEPTH - 1) && $urandom_range(0, 9) != 0) pn = DEPTH - 1 - sz;
      if (pn < 0) pn = 0;
      pp = $urandom_range(0, 2);
      fl = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 119) == 0);
      drive_cycle(pn, pp, fl, rs);
      check_state("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
